// File: rtl/dmem_port_arbiter_pkg.sv
// Shared encodings for the fetch/MEM memory port arbiter.
package dmem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    SzByte = 2'b00,
    SzHalf = 2'b01,
    SzWord = 2'b10
  } access_size_e;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  typedef enum logic {
    OwnIf = 1'b0,
    OwnDm = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_port_arbiter_rr.sv
// Two-requester round-robin grant; the last-winner flag advances on every grant.
module dmem_port_arbiter_rr (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_if,
  input  logic req_dm,
  output logic gnt_if,
  output logic gnt_dm
);

  logic last_dm_q;

  // On conflict the requester that did not win last time goes first.
  always_comb begin
    gnt_dm = en & req_dm & (~req_if | ~last_dm_q);
    gnt_if = en & req_if & (~req_dm | last_dm_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_dm_q <= 1'b0;
    end else if (gnt_if | gnt_dm) begin
      last_dm_q <= gnt_dm;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the MEM stage,
// counting a fixed read latency and returning a response pulse to the winner.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned LAT = 2,
  parameter int unsigned CW  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic        dm_rdun,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_w_enable,
  output logic [1:0]  mem_access_size,
  output logic        mem_rdun,
  input  logic [31:0] mem_data_out,
  output logic        busy
);

  arb_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  owner_e          owner_q, owner_d;
  logic            store_q, store_d;
  logic [31:0]     addr_d, wdata_d, if_rdata_d, dm_rdata_d;
  logic [1:0]      size_d;
  logic            rdun_d, we_d, if_rvalid_d, dm_rvalid_d;

  dmem_port_arbiter_rr u_rr (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q == StIdle),
    .req_if (if_req),
    .req_dm (dm_req),
    .gnt_if (if_gnt),
    .gnt_dm (dm_gnt)
  );

  assign busy = (state_q == StBusy);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    store_d     = store_q;
    addr_d      = mem_address;
    wdata_d     = mem_data_in;
    size_d      = mem_access_size;
    rdun_d      = mem_rdun;
    we_d        = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    case (state_q)
      StIdle: begin
        if (dm_gnt) begin
          state_d = StBusy;
          cnt_d   = CW'(LAT);
          owner_d = OwnDm;
          store_d = dm_we;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          size_d  = dm_size;
          rdun_d  = dm_rdun;
          we_d    = dm_we;
        end else if (if_gnt) begin
          state_d = StBusy;
          cnt_d   = CW'(LAT);
          owner_d = OwnIf;
          store_d = 1'b0;
          addr_d  = if_addr;
          wdata_d = 32'h0;
          size_d  = SzWord;
          rdun_d  = 1'b0;
        end
      end
      StBusy: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StIdle;
          if (owner_q == OwnDm) begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = store_q ? 32'h0 : mem_data_out;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_data_out;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      owner_q         <= OwnIf;
      store_q         <= 1'b0;
      mem_address     <= 32'h0;
      mem_data_in     <= 32'h0;
      mem_access_size <= 2'b00;
      mem_rdun        <= 1'b0;
      mem_w_enable    <= 1'b0;
      if_rvalid       <= 1'b0;
      dm_rvalid       <= 1'b0;
      if_rdata        <= 32'h0;
      dm_rdata        <= 32'h0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      owner_q         <= owner_d;
      store_q         <= store_d;
      mem_address     <= addr_d;
      mem_data_in     <= wdata_d;
      mem_access_size <= size_d;
      mem_rdun        <= rdun_d;
      mem_w_enable    <= we_d;
      if_rvalid       <= if_rvalid_d;
      dm_rvalid       <= dm_rvalid_d;
      if_rdata        <= if_rdata_d;
      dm_rdata        <= dm_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a little-endian byte memory model.
module tb_dmem_port_arbiter;

  localparam int unsigned LAT = 2;
  localparam int unsigned CW  = 4;
  localparam int          T   = LAT + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, dm_rdun;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [1:0]  dm_size;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_w_enable, mem_rdun, busy;
  logic [1:0]  mem_access_size;

  logic [7:0] mem [0:1027];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int we_cnt = 0;

  typedef struct {
    logic        own;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];
  logic grant_q[$];
  int   gcyc_q[$];

  dmem_port_arbiter #(.LAT(LAT), .CW(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_gnt          (if_gnt),
    .if_rvalid       (if_rvalid),
    .if_rdata        (if_rdata),
    .dm_req          (dm_req),
    .dm_addr         (dm_addr),
    .dm_wdata        (dm_wdata),
    .dm_we           (dm_we),
    .dm_size         (dm_size),
    .dm_rdun         (dm_rdun),
    .dm_gnt          (dm_gnt),
    .dm_rvalid       (dm_rvalid),
    .dm_rdata        (dm_rdata),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_w_enable    (mem_w_enable),
    .mem_access_size (mem_access_size),
    .mem_rdun        (mem_rdun),
    .mem_data_out    (mem_data_out),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] sz,
                                          input logic un);
    case (sz)
      2'b00:   return un ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
      2'b01:   return un ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] bytes_at(input logic [31:0] a);
    int i;
    i = int'(a[9:0]);
    return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
  endfunction

  // Memory model: data_out settles combinationally, so it is valid whenever sampled.
  always_comb begin
    int ma;
    ma = int'(mem_address[9:0]);
    mem_data_out = extract({mem[ma+3], mem[ma+2], mem[ma+1], mem[ma]},
                           mem_access_size, mem_rdun);
  end

  always @(posedge clk) begin
    int wa;
    wa = int'(mem_address[9:0]);
    if (mem_w_enable) begin
      mem[wa] <= mem_data_in[7:0];
      if (mem_access_size != 2'b00) mem[wa+1] <= mem_data_in[15:8];
      if (mem_access_size == 2'b10) begin
        mem[wa+2] <= mem_data_in[23:16];
        mem[wa+3] <= mem_data_in[31:24];
      end
    end
  end

  // Monitor: responses are popped before this cycle's grant is pushed.
  always @(negedge clk) begin
    exp_t e;
    if (mem_w_enable) we_cnt++;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (if_rvalid || dm_rvalid) begin
        check("rvalid_overlap", {31'h0, if_rvalid & dm_rvalid}, 32'h0);
        if (exp_q.size() == 0) begin
          check("spurious_rvalid", exp_q.size(), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("rsp_owner", {31'h0, dm_rvalid}, {31'h0, e.own});
          check("rsp_data", dm_rvalid ? dm_rdata : if_rdata, e.data);
          check("rsp_latency", cyc - e.cyc, T);
        end
      end
      if (dm_gnt) begin
        e.own  = 1'b1;
        e.data = dm_we ? 32'h0 : extract(bytes_at(dm_addr), dm_size, dm_rdun);
        e.cyc  = cyc;
        exp_q.push_back(e);
        grant_q.push_back(1'b1);
        gcyc_q.push_back(cyc);
      end else if (if_gnt) begin
        e.own  = 1'b0;
        e.data = bytes_at(if_addr);
        e.cyc  = cyc;
        exp_q.push_back(e);
        grant_q.push_back(1'b0);
        gcyc_q.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 30) begin
      tick();
      k++;
    end
    check({tag, "_idle"}, {31'h0, busy | (exp_q.size() != 0)}, 32'h0);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic un, input logic [31:0] exp);
    dm_req = 1'b1; dm_addr = a; dm_we = 1'b0; dm_size = sz; dm_rdun = un;
    @(negedge clk);
    check({tag, "_gnt"}, {31'h0, dm_gnt}, 32'h1);
    tick();
    dm_req = 1'b0;
    wait_idle(tag);
    check({tag, "_rdata"}, dm_rdata, exp);
  endtask

  initial begin
    int   g0, k;
    logic got;
    for (int i = 0; i < 1028; i++) mem[i] = 8'(i * 37 + 11);
    reset = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_rdun = 1'b0;
    if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0; dm_size = 2'b10;
    repeat (2) tick();
    @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_if_gnt", {31'h0, if_gnt}, 32'h0);
    check("rst_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
    check("rst_rdata", if_rdata | dm_rdata, 32'h0);
    check("rst_mem_addr", mem_address, 32'h0);
    check("rst_mem_ctl", {29'h0, mem_w_enable, mem_access_size}, 32'h0);
    tick();
    reset = 1'b0;

    // Lone fetch
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    check("t1_if_gnt", {31'h0, if_gnt}, 32'h1);
    check("t1_dm_gnt", {31'h0, dm_gnt}, 32'h0);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("t1_mem_addr", mem_address, 32'h100);
    check("t1_mem_size", {30'h0, mem_access_size}, 32'h2);
    check("t1_mem_we", {31'h0, mem_w_enable}, 32'h0);
    for (int i = 1; i <= int'(LAT); i++) begin
      if (i > 1) @(negedge clk);
      check("t1_busy", {31'h0, busy}, 32'h1);
      check("t1_early_rvalid", {31'h0, if_rvalid}, 32'h0);
      tick();
    end
    @(negedge clk);
    check("t1_if_rvalid", {31'h0, if_rvalid}, 32'h1);
    check("t1_busy_done", {31'h0, busy}, 32'h0);
    wait_idle("t1");

    // Store word, then loads of its bytes/halves
    we_cnt = 0;
    dm_req = 1'b1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; dm_we = 1'b1;
    dm_size = 2'b10; dm_rdun = 1'b0;
    @(negedge clk);
    check("t2_gnt", {31'h0, dm_gnt}, 32'h1);
    tick();
    dm_req = 1'b0;
    @(negedge clk);
    check("t2_mem_we", {31'h0, mem_w_enable}, 32'h1);
    check("t2_mem_wdata", mem_data_in, 32'hDEADBEEF);
    wait_idle("t2");
    check("t2_we_cycles", we_cnt, 32'd1);
    check("t2_store_rdata", dm_rdata, 32'h0);
    do_load("lbu", 32'h203, 2'b00, 1'b1, 32'h000000DE);
    do_load("lb", 32'h203, 2'b00, 1'b0, 32'hFFFFFFDE);
    do_load("lhu", 32'h202, 2'b01, 1'b1, 32'h0000DEAD);
    do_load("lh", 32'h200, 2'b01, 1'b0, 32'hFFFFBEEF);
    do_load("lw", 32'h200, 2'b10, 1'b0, 32'hDEADBEEF);

    // Data request arriving while a fetch is in flight
    if_req = 1'b1; if_addr = 32'h40;
    @(negedge clk);
    check("t4_if_gnt", {31'h0, if_gnt}, 32'h1);
    tick();
    if_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h200; dm_we = 1'b0; dm_size = 2'b10;
    for (int i = 1; i <= int'(LAT); i++) begin
      @(negedge clk);
      check("t4_dm_wait", {31'h0, dm_gnt}, 32'h0);
      tick();
    end
    @(negedge clk);
    check("t4_if_rvalid", {31'h0, if_rvalid}, 32'h1);
    check("t4_dm_gnt", {31'h0, dm_gnt}, 32'h1);
    tick();
    dm_req = 1'b0;
    wait_idle("t4");

    // Back-to-back loads with dm_req held
    dm_req = 1'b1; dm_addr = 32'h0; dm_size = 2'b10; dm_we = 1'b0;
    @(negedge clk);
    check("t6_gnt0", {31'h0, dm_gnt}, 32'h1);
    g0 = cyc;
    tick();
    dm_addr = 32'h4;
    k = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      got = dm_gnt;
      if (!got) begin
        tick();
        k++;
      end
    end
    check("t6_gnt_spacing", cyc - g0, T);
    tick();
    dm_req = 1'b0;
    wait_idle("t6");

    // Reset in the middle of a load, fetch pending
    dm_req = 1'b1; dm_addr = 32'h200; dm_we = 1'b0; dm_size = 2'b10;
    @(negedge clk);
    check("t5_dm_gnt", {31'h0, dm_gnt}, 32'h1);
    tick();
    dm_req = 1'b0; if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    check("t5_if_blocked", {31'h0, if_gnt}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("t5_no_rvalid", {30'h0, if_rvalid, dm_rvalid}, 32'h0);
    check("t5_busy", {31'h0, busy}, 32'h0);
    check("t5_rdata", if_rdata | dm_rdata, 32'h0);
    check("t5_mem_addr", mem_address, 32'h0);
    check("t5_mem_ctl", {29'h0, mem_w_enable, mem_access_size}, 32'h0);
    check("t5_mem_din", mem_data_in, 32'h0);
    check("t5_if_gnt", {31'h0, if_gnt}, 32'h1);
    tick();
    if_req = 1'b0;
    wait_idle("t5");

    // Contention held from reset: dm, if, dm, if
    reset = 1'b1;
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_addr = 32'h200; dm_we = 1'b0; dm_size = 2'b10;
    tick();
    tick();
    grant_q.delete();
    gcyc_q.delete();
    reset = 1'b0;
    k = 0;
    while (grant_q.size() < 4 && k < 40) begin
      tick();
      k++;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    check("t3_grant_count", grant_q.size(), 32'd4);
    if (grant_q.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t3_order", {31'h0, grant_q[i]}, (i % 2 == 0) ? 32'h1 : 32'h0);
        if (i > 0) check("t3_spacing", gcyc_q[i] - gcyc_q[i-1], T);
      end
    end
    wait_idle("t3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
